add_accum: RTL and testbench

//   Parametrised, registered successor to the LSC + Mul adder.

---
 rtl/add_accum.sv | 77 +++++++
 tb/tb_add_accum.sv | 121 ++++++++++++
 2 files changed

// File: rtl/add_accum.sv
// add_accum: registered LSC+Mul adder with single-add and burst-accumulate modes, handshaked in and out.
// Define ADD_ACCUM_SAT_EN to clamp the accumulator at 2^SUM_W-1 on overflow instead of wrapping.
module add_accum #(
  parameter int A_W   = 4,
  parameter int B_W   = 6,
  parameter int SUM_W = 6,
  parameter int CNT_W = 4
) (
  input  logic             Clk_In,
  input  logic             Rst_In,
  input  logic [A_W-1:0]   LSC_In,
  input  logic [B_W-1:0]   Mul_In,
  input  logic             Mode_In,
  input  logic             Last_In,
  input  logic             In_Valid_In,
  output logic             In_Ready_Out,
  output logic [SUM_W-1:0] Sum_Out,
  output logic             Ovf_Out,
  output logic [CNT_W-1:0] Cnt_Out,
  output logic             Out_Valid_Out,
  input  logic             Out_Ready_In
);
`ifdef ADD_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  state_t           state_q;
  logic [SUM_W-1:0] acc_q, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_acc_q, cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_q, ovf_d;
  logic [SUM_W+1:0] raw;
  logic             first, accept, done;
  assign In_Ready_Out  = !Rst_In & (state_q != HOLD | Out_Ready_In);
  assign Out_Valid_Out = state_q == HOLD;
  assign Sum_Out       = sum_q;
  assign Ovf_Out       = ovf_q;
  assign Cnt_Out       = cnt_q;
  // A beat taken outside ACC (IDLE, or HOLD being drained) starts a fresh burst.
  always_comb begin
    first  = state_q != ACC;
    accept = In_Valid_In & In_Ready_Out;
    done   = accept & (Last_In | (first & !Mode_In));
    raw    = (first ? '0 : {2'b00, acc_q}) + (SUM_W+2)'(LSC_In) + (SUM_W+2)'(Mul_In);
    ovf_d  = (!first & ovf_acc_q) | (|raw[SUM_W+1:SUM_W]);
    sum_d  = (SAT && ovf_d) ? '1 : raw[SUM_W-1:0];
    cnt_d  = first ? CNT_W'(1) : (&cnt_acc_q ? cnt_acc_q : cnt_acc_q + 1'b1);
  end
  always_ff @(posedge Clk_In) begin
    if (Rst_In) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      cnt_acc_q <= '0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        acc_q     <= sum_d;
        ovf_acc_q <= ovf_d;
        cnt_acc_q <= cnt_d;
      end
      if (done) begin
        sum_q   <= sum_d;
        ovf_q   <= ovf_d;
        cnt_q   <= cnt_d;
        state_q <= HOLD;
      end else if (accept) begin
        state_q <= ACC;
      end else if (state_q == HOLD && Out_Ready_In) begin
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_add_accum.sv
// tb_add_accum: directed table-driven checks of add_accum plus burst, stall, reset and saturation sequences.
module tb_add_accum;
  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] lsc = '0;
  logic [5:0] mul = '0, sum;
  logic       mode = 1'b0, last = 1'b0, in_valid = 1'b0, in_ready, ovf, out_valid, out_ready = 1'b1;
  logic [3:0] cnt;
  int checks = 0, errors = 0;
`ifdef ADD_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  add_accum dut (
    .Clk_In(clk), .Rst_In(rst), .LSC_In(lsc), .Mul_In(mul), .Mode_In(mode), .Last_In(last),
    .In_Valid_In(in_valid), .In_Ready_Out(in_ready), .Sum_Out(sum), .Ovf_Out(ovf), .Cnt_Out(cnt),
    .Out_Valid_Out(out_valid), .Out_Ready_In(out_ready)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] a;
    logic [5:0] b;
    logic [5:0] s;
    logic       o;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic beat(input int a, input int b, input logic m, input logic l);
    lsc = 4'(a); mul = 6'(b); mode = m; last = l; in_valid = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic result(input string name, input int s, input int o, input int c);
    chk({name, " valid"}, int'(out_valid), 1);
    chk({name, " sum"}, int'(sum), s);
    chk({name, " ovf"}, int'(ovf), o);
    chk({name, " cnt"}, int'(cnt), c);
  endtask
  initial begin
    vecs[0] = '{4'd9, 6'd20, 6'd29, 1'b0};
    vecs[1] = '{4'd15, 6'd63, SAT ? 6'd63 : 6'd14, 1'b1};
    vecs[2] = '{4'd0, 6'd0, 6'd0, 1'b0};
    vecs[3] = '{4'd10, 6'd53, 6'd63, 1'b0};
    vecs[4] = '{4'd1, 6'd63, SAT ? 6'd63 : 6'd0, 1'b1};
    vecs[5] = '{4'd7, 6'd7, 6'd14, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", int'(in_ready), 0);
    chk("rst valid", int'(out_valid), 0);
    chk("rst sum", int'(sum), 0);
    chk("rst ovf", int'(ovf), 0);
    chk("rst cnt", int'(cnt), 0);
    rst = 1'b0;
    // single adds presented back-to-back; HOLD must accept each with no bubble
    for (int i = 0; i < 6; i++) begin
      beat(vecs[i].a, vecs[i].b, 1'b0, 1'b0);
      result($sformatf("vec%0d", i), vecs[i].s, vecs[i].o, 1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain valid", int'(out_valid), 0);
    chk("retain sum", int'(sum), 14);
    // overflowing two-beat burst: 78 -> 14, 14+78 -> 28 (sat 63)
    beat(15, 63, 1'b1, 1'b0);
    chk("ovfb mid valid", int'(out_valid), 0);
    beat(15, 63, 1'b0, 1'b1);
    in_valid = 1'b0;
    result("ovf burst", SAT ? 63 : 28, 1, 2);
    // three-beat burst with an idle gap in ACC; ovf must clear at burst start
    beat(1, 2, 1'b1, 1'b0);
    chk("b3 beat1 valid", int'(out_valid), 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b3 gap valid", int'(out_valid), 0);
    beat(3, 4, 1'b0, 1'b0);
    chk("b3 beat2 valid", int'(out_valid), 0);
    beat(5, 6, 1'b0, 1'b1);
    result("burst3", 21, 0, 3);
    // consumer stall with a new beat pending
    out_ready = 1'b0;
    lsc = 4'd2; mul = 6'd3; mode = 1'b0; last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall in_ready", int'(in_ready), 0);
      chk("stall sum", int'(sum), 21);
      chk("stall valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    result("after stall", 5, 0, 1);
    // reset mid-burst discards partial accumulation
    beat(7, 7, 1'b1, 1'b0);
    beat(7, 7, 1'b1, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("midrst valid", int'(out_valid), 0);
    chk("midrst sum", int'(sum), 0);
    chk("midrst cnt", int'(cnt), 0);
    chk("midrst ovf", int'(ovf), 0);
    rst = 1'b0;
    beat(1, 1, 1'b1, 1'b1);
    in_valid = 1'b0;
    result("post rst", 2, 0, 1);
    // 20-beat burst saturates the counter
    for (int i = 1; i <= 20; i++) beat(0, 1, 1'b1, i == 20);
    in_valid = 1'b0;
    result("cnt sat", 20, 0, 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
